// File: rtl/vga_capture_pkg.sv
// Shared definitions for the VGA receive-side monitor: default 640x480
// timing, derived totals/offsets, counter width and the lock FSM states.
package vga_capture_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int H_START   = H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int V_START   = V_SYNC + V_BACK;

    localparam int CW = 10;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    // Increment that sticks at all-ones so a missing sync cannot wrap.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Stage-1 register and edge detector for one active-low sync line.
// o_fall marks an assertion (1->0), o_rise a deassertion (0->1), both
// valid for the cycle in which the new level sits in the stage-1 flop.
module vga_sync_edge
    import vga_capture_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sync,
    output logic o_fall,
    output logic o_rise
);

    logic s1_q, s2_q;

    // Capture plus one cycle of history; idle (deasserted) level out of reset
    // so a stream that starts in sync still yields an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= i_sync;
            s2_q <= s1_q;
        end
    end

    assign o_fall = s2_q & ~s1_q;
    assign o_rise = ~s2_q & s1_q;

endmodule

// File: rtl/vga_capture.sv
// VGA receive monitor: recovers (x, y), data-enable and lock from the
// hsync/vsync/rgb stream and counts timing violations while locked.
// Optional pixel probe is built only when VGA_CAPTURE_PROBE_EN is defined.
// Two-flop latency: stage-1 capture, then registered outputs.
module vga_capture
    import vga_capture_pkg::*;
#(
    parameter int H_VIS = H_VISIBLE,
    parameter int H_FP  = H_FRONT,
    parameter int H_SW  = H_SYNC,
    parameter int H_BP  = H_BACK,
    parameter int V_VIS = V_VISIBLE,
    parameter int V_FP  = V_FRONT,
    parameter int V_SW  = V_SYNC,
    parameter int V_BP  = V_BACK
)(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_hsync,
    input  logic       i_vsync,
    input  logic [2:0] i_rgb,
    output logic       o_locked,
    output logic       o_de,
    output logic [9:0] o_hpos,
    output logic [9:0] o_vpos,
    output logic [2:0] o_rgb,
    output logic       o_frame_start,
    output logic       o_err,
    output logic [7:0] o_err_cnt,
    input  logic [9:0] i_probe_x,
    input  logic [9:0] i_probe_y,
    output logic [2:0] o_probe_rgb,
    output logic       o_probe_valid
);

    localparam logic [CW-1:0] HTOT_M1 = CW'(H_VIS + H_FP + H_SW + H_BP - 1);
    localparam logic [CW-1:0] HSW_M1  = CW'(H_SW - 1);
    localparam logic [CW-1:0] VTOT_M1 = CW'(V_VIS + V_FP + V_SW + V_BP - 1);
    localparam logic [CW-1:0] HST     = CW'(H_SW + H_BP);
    localparam logic [CW-1:0] HEND    = CW'(H_SW + H_BP + H_VIS);
    localparam logic [CW-1:0] VST     = CW'(V_SW + V_BP);
    localparam logic [CW-1:0] VEND    = CW'(V_SW + V_BP + V_VIS);

    logic          h_fall, h_rise, v_fall, v_rise_unused;
    logic [2:0]    rgb_q;
    logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
    state_e        state_q, state_d;
    logic          fail, err_d, de_d;
    logic [9:0]    hpos_d, vpos_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          de_q, fs_q, err_q;
    logic [9:0]    hpos_q, vpos_q;
    logic [2:0]    rgb_o_q;

    vga_sync_edge u_hs (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_sync(i_hsync),
                        .o_fall(h_fall), .o_rise(h_rise));
    vga_sync_edge u_vs (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_sync(i_vsync),
                        .o_fall(v_fall), .o_rise(v_rise_unused));

    // Stage-1 pixel capture, aligned with the sync edge detectors.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rgb_q <= '0;
        else          rgb_q <= i_rgb;
    end

    // Position of the pixel now in stage 1; vsync clear beats hsync increment.
    always_comb begin
        hc_d = h_fall ? '0 : sat_inc(hc_q);
        vc_d = vc_q;
        if (v_fall)      vc_d = '0;
        else if (h_fall) vc_d = sat_inc(vc_q);
    end

    // Counters hold the previous pixel's position, so edge checks compare
    // against the last count before the edge. A line past the last without
    // vsync, or a saturated hc, means sync is lost.
    assign fail = (h_fall && hc_q != HTOT_M1)
               || (h_rise && hc_q != HSW_M1)
               || (v_fall && vc_q != VTOT_M1)
               || (h_fall && !v_fall && vc_q >= VTOT_M1)
               || (!h_fall && hc_q == CNT_MAX);

    // Lock FSM next state; errors are reported only when falling out of LOCKED.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            SEARCH:  if (v_fall) state_d = MEASURE;
            MEASURE: begin
                if (fail)        state_d = SEARCH;
                else if (v_fall) state_d = LOCKED;
            end
            LOCKED:  if (fail) begin
                state_d = SEARCH;
                err_d   = 1'b1;
            end
            default: state_d = SEARCH;
        endcase
    end

    assign err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    assign de_d   = (hc_d >= HST) && (hc_d < HEND) && (vc_d >= VST) && (vc_d < VEND)
                 && (state_d == LOCKED);
    assign hpos_d = de_d ? hc_d - HST : '0;
    assign vpos_d = de_d ? vc_d - VST : '0;

    // Counter and FSM state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= SEARCH;
            hc_q      <= '0;
            vc_q      <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Output stage; lock decode comes from state_q, which updates on this same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            de_q    <= 1'b0;
            hpos_q  <= '0;
            vpos_q  <= '0;
            rgb_o_q <= '0;
            fs_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            de_q    <= de_d;
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            rgb_o_q <= de_d ? rgb_q : 3'd0;
            fs_q    <= de_d && (hc_d == HST) && (vc_d == VST);
            err_q   <= err_d;
        end
    end

    assign o_locked      = (state_q == LOCKED);
    assign o_de          = de_q;
    assign o_hpos        = hpos_q;
    assign o_vpos        = vpos_q;
    assign o_rgb         = rgb_o_q;
    assign o_frame_start = fs_q;
    assign o_err         = err_q;
    assign o_err_cnt     = err_cnt_q;

`ifdef VGA_CAPTURE_PROBE_EN
    logic       probe_hit;
    logic [2:0] probe_rgb_q;
    logic       probe_valid_q;

    assign probe_hit = de_d && (hpos_d == i_probe_x) && (vpos_d == i_probe_y);

    // Latch the probed pixel; the pulse lines up with that pixel's outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            probe_rgb_q   <= '0;
            probe_valid_q <= 1'b0;
        end else begin
            probe_valid_q <= probe_hit;
            if (probe_hit) probe_rgb_q <= rgb_q;
        end
    end

    assign o_probe_rgb   = probe_rgb_q;
    assign o_probe_valid = probe_valid_q;
`else
    logic unused_probe;
    assign unused_probe  = ^{i_probe_x, i_probe_y};
    assign o_probe_rgb   = 3'd0;
    assign o_probe_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a shrunken timing (15 x 10 frame):
// table of pixel vectors plus sequences for lock, reset, errors and probe.
module tb_vga_capture;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 6, VF = 1, VS = 1, VB = 2;
    localparam int HT = HV + HF + HS + HB;   // 15, visible gx 5..12
    localparam int VT = VV + VF + VS + VB;   // 10, visible gl 3..8

    logic       clk = 1'b0, rst_n = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic [2:0] rgb = 3'd0;
    logic [9:0] probe_x = 10'd7, probe_y = 10'd5;
    logic       o_locked, o_de, o_frame_start, o_err, o_probe_valid;
    logic [9:0] o_hpos, o_vpos;
    logic [2:0] o_rgb, o_probe_rgb;
    logic [7:0] o_err_cnt;
    logic [38:0] all_outs;

    vga_capture #(.H_VIS(HV), .H_FP(HF), .H_SW(HS), .H_BP(HB),
                  .V_VIS(VV), .V_FP(VF), .V_SW(VS), .V_BP(VB)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_hsync(hsync), .i_vsync(vsync), .i_rgb(rgb),
        .o_locked(o_locked), .o_de(o_de), .o_hpos(o_hpos), .o_vpos(o_vpos),
        .o_rgb(o_rgb), .o_frame_start(o_frame_start), .o_err(o_err),
        .o_err_cnt(o_err_cnt), .i_probe_x(probe_x), .i_probe_y(probe_y),
        .o_probe_rgb(o_probe_rgb), .o_probe_valid(o_probe_valid));

    assign all_outs = {o_locked, o_de, o_hpos, o_vpos, o_rgb, o_frame_start,
                       o_err, o_err_cnt, o_probe_rgb, o_probe_valid};

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int gx = 0, gl = 0, stretch_line = -1, tx = -1, tl = -1;
    bit hold_h = 0, hold_v = 0, vedge = 0;
    logic [2:0] tc = 3'd0;
    logic last_vs = 1'b1;
    int pa_x = -1, pa_l = -1, obs_x = -1, obs_l = -1;
    int probe_bad = 0;

    typedef struct {
        int gx; int gl; logic [2:0] rgb;
        logic de; logic [9:0] hpos; logic [9:0] vpos; logic [2:0] orgb; logic fs;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One pixel: drive generator output, clock, advance generator, sample.
    // After the tick, outputs describe the pixel applied on the previous tick.
    task automatic tick();
        hsync = hold_h ? 1'b1 : ((gx < HS) ? 1'b0 : 1'b1);
        vsync = hold_v ? 1'b1 : ((gl < VS) ? 1'b0 : 1'b1);
        rgb   = (gx == tx && gl == tl) ? tc : 3'd0;
        vedge = last_vs && !vsync;
        last_vs = vsync;
        @(posedge clk);
        obs_x = pa_x; obs_l = pa_l;
        pa_x = gx; pa_l = gl;
        gx++;
        if (gx == ((gl == stretch_line) ? HT + 1 : HT)) begin
            gx = 0;
            if (gl == stretch_line) stretch_line = -1;
            gl = (gl + 1) % VT;
        end
        #1;
        if (o_probe_rgb != 3'd0 || o_probe_valid) probe_bad++;
    endtask

    task automatic run_to(input int x, input int l);
        for (int i = 0; i < 400 && !(gx == x && gl == l); i++) tick();
    endtask

    // Lock must rise exactly one tick after the tick that applied the 2nd vsync edge.
    task automatic lock_seq(input string name);
        int edges = 0;
        bit done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            tick();
            if (vedge) begin
                edges++;
                if (edges == 2) begin
                    chk({name, "_pre"}, o_locked, 1'b0);
                    tick();
                    chk(name, o_locked, 1'b1);
                    done = 1;
                end
            end
        end
        if (!done) chk({name, "_timeout"}, done, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit hit, found;
        int de_n, rgb_n, fs_n, err_n, lk, ec, vn, sat_at;
        logic [19:0] hitpos;

        vecs[0] = '{5,  3, 3'd5, 1'b1, 10'd0, 10'd0, 3'd5, 1'b1};
        vecs[1] = '{6,  3, 3'd3, 1'b1, 10'd1, 10'd0, 3'd3, 1'b0};
        vecs[2] = '{12, 8, 3'd7, 1'b1, 10'd7, 10'd5, 3'd7, 1'b0};
        vecs[3] = '{13, 8, 3'd7, 1'b0, 10'd0, 10'd0, 3'd0, 1'b0};
        vecs[4] = '{4,  4, 3'd6, 1'b0, 10'd0, 10'd0, 3'd0, 1'b0};
        vecs[5] = '{10, 4, 3'd4, 1'b1, 10'd5, 10'd1, 3'd4, 1'b0};
        vecs[6] = '{7,  2, 3'd2, 1'b0, 10'd0, 10'd0, 3'd0, 1'b0};
        vecs[7] = '{7,  9, 3'd1, 1'b0, 10'd0, 10'd0, 3'd0, 1'b0};
        vecs[8] = '{0,  0, 3'd7, 1'b0, 10'd0, 10'd0, 3'd0, 1'b0};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs, 39'd0);

        // First lock from reset, stream starting mid-frame
        gl = 8; gx = 0;
        rst_n = 1'b1;
        lock_seq("first_lock");
        chk("err_cnt_clean", o_err_cnt, 8'd0);

        // Pixel vector table
        for (int k = 0; k < 9; k++) begin
            hit = 0;
            tx = vecs[k].gx; tl = vecs[k].gl; tc = vecs[k].rgb;
            for (int i = 0; i < 400 && !hit; i++) begin
                tick();
                if (i > 0 && obs_x == vecs[k].gx && obs_l == vecs[k].gl) hit = 1;
            end
            chk($sformatf("vec%0d", k),
                {hit, o_de, o_hpos, o_vpos, o_rgb, o_frame_start},
                {1'b1, vecs[k].de, vecs[k].hpos, vecs[k].vpos, vecs[k].orgb, vecs[k].fs});
        end

        // One full frame with a single coloured pixel at (5,1)
        tx = 10; tl = 4; tc = 3'b100;
        de_n = 0; rgb_n = 0; fs_n = 0; hitpos = '0;
        for (int i = 0; i < HT * VT; i++) begin
            tick();
            if (o_de) de_n++;
            if (o_frame_start) fs_n++;
            if (o_rgb != 3'd0) begin
                rgb_n++;
                hitpos = {o_hpos, o_vpos};
            end
        end
        chk("frame_de_count", de_n, HV * VV);
        chk("frame_rgb_count", rgb_n, 1);
        chk("frame_fs_count", fs_n, 1);
        chk("frame_rgb_pos", hitpos, {10'd5, 10'd1});

        // Asynchronous reset mid-line, then relock
        run_to(8, 6);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs, 39'd0);
        tick();
        tick();
        rst_n = 1'b1;
        lock_seq("lock_after_reset");

        // One line stretched by a pixel while locked
        run_to(0, 4);
        stretch_line = 5;
        err_n = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (o_err) begin
                err_n++;
                if (err_n == 1) chk("err_pulse_state", {o_locked, o_err_cnt}, {1'b0, 8'd1});
            end
        end
        chk("err_pulse_count", err_n, 1);
        lock_seq("relock_after_err");
        chk("err_cnt_after_relock", o_err_cnt, 8'd1);

        // Both syncs lost while locked: hc saturation is an error
        run_to(5, 4);
        hold_h = 1; hold_v = 1;
        found = 0; sat_at = -1;
        for (int i = 0; i < 1200 && !found; i++) begin
            tick();
            if (o_err) begin
                found = 1;
                sat_at = i;
            end
        end
        chk("sat_err", {found, o_err_cnt, o_locked}, {1'b1, 8'd2, 1'b0});
        chk("sat_err_timing", (sat_at >= 1015 && sat_at <= 1025), 1'b1);
        hold_v = 0;

        // hsync stuck high from reset: never locks, no errors counted
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        lk = 0; ec = 0;
        for (int i = 0; i < 5 * HT * VT; i++) begin
            tick();
            if (o_locked) lk++;
            if (o_err_cnt != 8'd0) ec++;
        end
        chk("hold_no_lock", lk, 0);
        chk("hold_no_err", ec, 0);
        hold_h = 0;
        lock_seq("lock_for_probe");

        // Probe at the last visible pixel (7,5)
        tx = 12; tl = 8; tc = 3'b011;
`ifdef VGA_CAPTURE_PROBE_EN
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if (o_probe_valid) found = 1;
        end
        chk("probe_hit", {found, o_de, o_hpos, o_vpos, o_probe_rgb, o_rgb},
            {1'b1, 1'b1, 10'd7, 10'd5, 3'b011, 3'b011});
        vn = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_probe_valid) vn++;
        end
        chk("probe_hold", {o_probe_rgb, 8'(vn)}, {3'b011, 8'd0});
`else
        for (int i = 0; i < HT * VT; i++) tick();
        chk("probe_off", probe_bad, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
